note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_scheduler.sv | 115 +++++++++++
 tb/tb_note_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// note_scheduler: timestamped note-event FIFO that issues due events to the lowest free note slot
module note_scheduler #(
  parameter int COUNT = 3,
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cpu_write,
  input  logic              cpu_read,
  input  logic [1:0]        cpu_addr,
  input  logic [31:0]       cpu_data_in,
  output logic [31:0]       cpu_data_out,
  input  logic              tick,
  input  logic [COUNT-1:0]  slot_active,
  output logic              note_write,
  output logic [WIDTH-1:0]  note_addr,
  output logic [31:0]       note_data,
  output logic              irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  typedef enum logic [1:0] {IDLE, ALLOC, ISSUE, HOLD} state_t;
  state_t            r_state, w_next;
  logic [31:0]       r_mem [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [LW-1:0]     r_level;
  logic [15:0]       r_time;
  logic              r_en, r_ovf;
  logic [1:0]        r_rst_sync;
  logic [WIDTH-1:0]  r_slot, w_free;
  logic              w_ev_wr, w_ctrl_wr, w_time_wr, w_flush, w_full, w_empty;
  logic              w_push, w_pop, w_due, w_found;
  logic [31:0]       w_head, w_status;
  logic signed [15:0] w_diff;
  assign w_ev_wr   = cpu_write && cpu_addr == 2'd0;
  assign w_ctrl_wr = cpu_write && cpu_addr == 2'd1;
  assign w_time_wr = cpu_write && cpu_addr == 2'd3;
  assign w_flush   = w_ctrl_wr && cpu_data_in[1];
  assign w_full    = r_level == LW'(DEPTH);
  assign w_empty   = r_level == '0;
  assign w_push    = w_ev_wr && !w_full && !w_flush;
  assign w_pop     = r_state == ISSUE && !w_flush;
  assign w_head    = r_mem[r_rp];
  assign w_diff    = $signed(r_time - w_head[31:16]);
  assign w_due     = w_diff >= 16'sd0;
  assign irq       = r_en && r_level <= LW'(DEPTH / 4);
  assign w_status  = {r_ovf, w_full, w_empty, 1'b0, r_state, {(26 - LW){1'b0}}, r_level};
  assign cpu_data_out = !cpu_read ? 32'h0 :
                        cpu_addr == 2'd1 ? {31'h0, r_en} :
                        cpu_addr == 2'd2 ? w_status :
                        cpu_addr == 2'd3 ? {16'h0, r_time} : 32'h0;
  // release of the async reset is re-timed so the FSM only starts after two clean edges
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) r_rst_sync <= 2'b00;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  // event storage; contents need no reset since level/pointers qualify them
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= cpu_data_in;
  // FIFO pointers and occupancy; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      r_wp    <= w_flush ? '0 : r_wp + PW'(w_push);
      r_rp    <= w_flush ? '0 : r_rp + PW'(w_pop);
      r_level <= w_flush ? '0 : r_level + LW'(w_push) - LW'(w_pop);
    end
  // control registers and song time; a TIME write beats a simultaneous tick
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      r_en   <= 1'b0;
      r_ovf  <= 1'b0;
      r_time <= '0;
    end else begin
      r_en   <= w_ctrl_wr ? cpu_data_in[0] : r_en;
      r_ovf  <= (r_ovf | (w_ev_wr & w_full)) & !(w_ctrl_wr & cpu_data_in[2]);
      r_time <= w_time_wr ? cpu_data_in[15:0] : r_time + 16'(tick);
    end
  // lowest-index idle slot
  always_comb begin
    w_found = 1'b0;
    w_free  = '0;
    for (int i = COUNT - 1; i >= 0; i--)
      if (!slot_active[i]) begin
        w_found = 1'b1;
        w_free  = WIDTH'(i);
      end
  end
  // FSM state and chosen slot
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      r_state <= IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_next;
      r_slot  <= (r_state == ALLOC && w_found) ? w_free : r_slot;
    end
  // next state and slot write port; flush overrides everything
  always_comb begin
    w_next     = r_state;
    note_write = w_pop;
    note_addr  = w_pop ? r_slot : '0;
    note_data  = w_pop ? {16'h0, w_head[15:0]} : 32'h0;
    case (r_state)
      IDLE:    w_next = (r_rst_sync[1] && r_en && !w_empty && w_due) ? ALLOC : IDLE;
      ALLOC:   w_next = !r_en ? IDLE : w_found ? ISSUE : ALLOC;
      ISSUE:   w_next = HOLD;
      default: w_next = IDLE;
    endcase
    if (w_flush) w_next = IDLE;
  end
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed self-checking bench for note_scheduler
module tb_note_scheduler;
  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        cpu_write = 1'b0, cpu_read = 1'b0, tick = 1'b0;
  logic [1:0]  cpu_addr = '0;
  logic [31:0] cpu_data_in = '0, cpu_data_out, note_data;
  logic [2:0]  slot_active = '0;
  logic        note_write, irq;
  logic [1:0]  note_addr;
  logic [31:0] rv;
  int checks = 0, failures = 0;

  note_scheduler dut (
    .clk(clk), .Reset(Reset), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .tick(tick), .slot_active(slot_active), .note_write(note_write),
    .note_addr(note_addr), .note_data(note_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cpu_write = 1'b1;
    cpu_addr = a;
    cpu_data_in = d;
    cyc();
    cpu_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cpu_addr = a;
    cpu_read = 1'b1;
    #1 d = cpu_data_out;
    cpu_read = 1'b0;
  endtask

  task automatic push(input logic [15:0] ts, input logic [15:0] word);
    wr(2'd0, {ts, word});
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic expect_note(input string tag, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!note_write && n < 40) begin
      cyc();
      n++;
    end
    check({tag, "_seen"}, 32'(note_write), 32'd1);
    check({tag, "_addr"}, 32'(note_addr), a);
    check({tag, "_data"}, note_data, d);
    cyc();
    check({tag, "_one_cycle"}, 32'(note_write), 32'd0);
    cyc();
  endtask

  initial begin
    #1;
    check("rst_note_write", 32'(note_write), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_data_out_idle", cpu_data_out, 0);
    rd(2'd2, rv); check("rst_status", rv, 32'h2000_0000);
    cyc(); cyc();
    Reset = 1'b1;
    cyc(); cyc(); cyc();
    // V-1
    push(16'd5, 16'h0012);
    rd(2'd2, rv); check("v1_level1", rv, 32'h0000_0001);
    wr(2'd1, 32'h1);
    check("v1_irq", 32'(irq), 1);
    repeat (4) do_tick();
    cyc();
    check("v1_not_due", 32'(note_write), 0);
    rd(2'd2, rv); check("v1_still_idle", rv, 32'h0000_0001);
    do_tick();
    expect_note("v1", 0, 32'h0000_0012);
    rd(2'd2, rv); check("v1_level0", rv, 32'h2000_0000);
    // V-2
    slot_active = 3'b011;
    push(16'd0, 16'h0034);
    expect_note("v2_slot2", 2, 32'h0000_0034);
    slot_active = 3'b111;
    push(16'd0, 16'h0056);
    repeat (6) cyc();
    check("v2_stall_nowrite", 32'(note_write), 0);
    rd(2'd2, rv); check("v2_stall_alloc", rv, 32'h0400_0001);
    slot_active = 3'b101;
    expect_note("v2_slot1", 1, 32'h0000_0056);
    slot_active = 3'b000;
    // V-3
    wr(2'd3, 32'h0000_FFFE);
    rd(2'd3, rv); check("v3_time_load", rv, 32'h0000_FFFE);
    push(16'h0001, 16'h0078);
    do_tick(); cyc(); cyc();
    rd(2'd2, rv); check("v3_wait1", rv, 32'h0000_0001);
    do_tick(); cyc(); cyc();
    rd(2'd3, rv); check("v3_wrap", rv, 32'h0000_0000);
    rd(2'd2, rv); check("v3_wait2", rv, 32'h0000_0001);
    do_tick();
    expect_note("v3_due", 0, 32'h0000_0078);
    wr(2'd3, 32'h0000_0005);
    push(16'hFFF0, 16'h009A);
    expect_note("v3_past", 0, 32'h0000_009A);
    tick = 1'b1;
    wr(2'd3, 32'h0000_1234);
    tick = 1'b0;
    rd(2'd3, rv); check("time_write_wins", rv, 32'h0000_1234);
    do_tick();
    rd(2'd3, rv); check("time_tick", rv, 32'h0000_1235);
    // V-4
    wr(2'd1, 32'h0);
    for (int i = 0; i < 17; i++) push(16'h1335, 16'(i));
    rd(2'd2, rv); check("v4_full_ovf", rv, 32'hC000_0010);
    check("v4_irq_disabled", 32'(irq), 0);
    wr(2'd1, 32'h4);
    rd(2'd2, rv); check("v4_ovf_clr", rv, 32'h4000_0010);
    wr(2'd1, 32'h1);
    check("v4_irq_full", 32'(irq), 0);
    wr(2'd1, 32'h3);
    rd(2'd2, rv); check("v4_flush", rv, 32'h2000_0000);
    check("v4_irq_empty", 32'(irq), 1);
    // V-5
    wr(2'd3, 32'h0000_0010);
    push(16'd0, 16'h00BB);
    for (int n = 0; n < 10; n++) begin
      rd(2'd2, rv);
      if (rv[27:26] == 2'd2) break;
      cyc();
    end
    check("v5_reach_issue", 32'(rv[27:26]), 2);
    check("v5_issue_write", 32'(note_write), 1);
    cpu_write = 1'b1; cpu_addr = 2'd1; cpu_data_in = 32'h3;
    #1 check("v5_flush_suppress", 32'(note_write), 0);
    check("v5_flush_addr", 32'(note_addr), 0);
    cyc();
    cpu_write = 1'b0;
    rd(2'd2, rv); check("v5_idle_empty", rv, 32'h2000_0000);
    // V-6
    wr(2'd1, 32'h0);
    push(16'd0, 16'h00A1); push(16'd0, 16'h00A2); push(16'd0, 16'h00A3);
    wr(2'd1, 32'h1);
    for (int n = 0; n < 10 && !note_write; n++) cyc();
    check("v6_issue", 32'(note_data), 32'h0000_00A1);
    cyc();
    rd(2'd2, rv); check("v6_hold", rv, 32'h0C00_0002);
    #2 Reset = 1'b0;
    #1 check("v6_rst_write", 32'(note_write), 0);
    check("v6_rst_addr", 32'(note_addr), 0);
    check("v6_rst_data", note_data, 0);
    check("v6_rst_irq", 32'(irq), 0);
    rd(2'd2, rv); check("v6_rst_status", rv, 32'h2000_0000);
    cyc(); cyc();
    Reset = 1'b1;
    rd(2'd3, rv); check("v6_time0", rv, 32'h0);
    cyc(); cyc(); cyc();
    check("v6_no_write", 32'(note_write), 0);
    rd(2'd2, rv); check("v6_post_status", rv, 32'h2000_0000);
    wr(2'd1, 32'h1);
    push(16'd0, 16'h00C7);
    expect_note("v6_restart", 0, 32'h0000_00C7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
